// File: rtl/dco_tune_sequencer.sv
// Bang-bang DCO frequency-acquisition sequencer: integrates PD votes,
// issues single-cycle inc/dec steps with settle hold-off, tracks lock.
module dco_tune_sequencer #(
    parameter int ACC_WIDTH     = 6,
    parameter int THRESH        = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int LOCK_FLIPS    = 4,
    parameter int UNLOCK_RUN    = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic early,
    input  logic late,
    output logic inc,
    output logic dec,
    output logic locked,
    output logic busy
);

    localparam int SW = $clog2(SETTLE_CYCLES + 1);
    localparam int RW = $clog2(UNLOCK_RUN + 1);
    localparam int FW = $clog2(LOCK_FLIPS + 1);

    localparam logic signed [ACC_WIDTH-1:0] TH_POS  = ACC_WIDTH'(THRESH);
    localparam logic signed [ACC_WIDTH-1:0] TH_NEG  = ACC_WIDTH'(-THRESH);
    localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = ACC_WIDTH'(1);
    localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES);
    localparam logic [RW-1:0] RUN_MAX   = RW'(UNLOCK_RUN);
    localparam logic [FW-1:0] FLIP_MAX  = FW'(LOCK_FLIPS);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        STEP,
        SETTLE
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d, acc_sum;
    logic [SW-1:0]                 settle_q, settle_d;
    logic [RW-1:0]                 run_q, run_d;
    logic [FW-1:0]                 flip_q, flip_d;
    logic                          dir_valid_q, dir_valid_d;
    logic                          dir_q, dir_d;
    logic                          inc_q, inc_d;
    logic                          dec_q, dec_d;
    logic                          locked_q, locked_d;
    logic                          step_up, step_dn;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            settle_q    <= '0;
            run_q       <= '0;
            flip_q      <= '0;
            dir_valid_q <= 1'b0;
            dir_q       <= 1'b0;
            inc_q       <= 1'b0;
            dec_q       <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            settle_q    <= settle_d;
            run_q       <= run_d;
            flip_q      <= flip_d;
            dir_valid_q <= dir_valid_d;
            dir_q       <= dir_d;
            inc_q       <= inc_d;
            dec_q       <= dec_d;
            locked_q    <= locked_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_sum     = acc_q;
        settle_d    = settle_q;
        run_d       = run_q;
        flip_d      = flip_q;
        dir_valid_d = dir_valid_q;
        dir_d       = dir_q;
        inc_d       = 1'b0;
        dec_d       = 1'b0;
        locked_d    = locked_q;
        step_up     = 1'b0;
        step_dn     = 1'b0;

        if (!enable) begin
            state_d     = IDLE;
            acc_d       = '0;
            settle_d    = '0;
            run_d       = '0;
            flip_d      = '0;
            dir_valid_d = 1'b0;
            dir_d       = 1'b0;
            locked_d    = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ACQUIRE;
                    acc_d   = '0;
                end
                ACQUIRE: begin
                    if (late && !early) begin
                        acc_sum = acc_q + ACC_ONE;
                    end else if (early && !late) begin
                        acc_sum = acc_q - ACC_ONE;
                    end
                    acc_d   = acc_sum;
                    step_up = (acc_sum == TH_POS);
                    step_dn = (acc_sum == TH_NEG);
                    if (step_up || step_dn) begin
                        acc_d   = '0;
                        state_d = STEP;
                        inc_d   = step_up;
                        dec_d   = step_dn;
                        // history only moves on an actual step
                        if (!dir_valid_q || (dir_q == step_up)) begin
                            run_d  = (run_q == RUN_MAX) ? RUN_MAX : run_q + RW'(1);
                            flip_d = '0;
                        end else begin
                            flip_d = (flip_q == FLIP_MAX) ? FLIP_MAX : flip_q + FW'(1);
                            run_d  = RW'(1);
                        end
                        dir_valid_d = 1'b1;
                        dir_d       = step_up;
                        if (flip_d == FLIP_MAX) begin
                            locked_d = 1'b1;
                        end else if (locked_q && (run_d == RUN_MAX)) begin
                            locked_d = 1'b0;
                        end
                    end
                end
                STEP: begin
                    state_d  = SETTLE;
                    settle_d = SETTLE_LD;
                end
                SETTLE: begin
                    if (settle_q <= SW'(1)) begin
                        settle_d = '0;
                        state_d  = ACQUIRE;
                    end else begin
                        settle_d = settle_q - SW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign inc    = inc_q;
    assign dec    = dec_q;
    assign locked = locked_q;
    assign busy   = (state_q == STEP) || (state_q == SETTLE);

endmodule

// File: tb/tb_dco_tune_sequencer.sv
// Randomized + directed bench for dco_tune_sequencer against a
// vote/hold-off/step-history reference model.
module tb_dco_tune_sequencer;

    localparam int TH   = 8;
    localparam int SC   = 4;
    localparam int LF   = 4;
    localparam int UR   = 3;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic early;
    logic late;
    logic inc;
    logic dec;
    logic locked;
    logic busy;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    bit m_active;
    int m_acc;
    int m_hold;
    int m_hist[$];
    bit m_locked;
    bit m_inc;
    bit m_dec;

    dco_tune_sequencer #(
        .ACC_WIDTH    (6),
        .THRESH       (TH),
        .SETTLE_CYCLES(SC),
        .LOCK_FLIPS   (LF),
        .UNLOCK_RUN   (UR)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .early (early),
        .late  (late),
        .inc   (inc),
        .dec   (dec),
        .locked(locked),
        .busy  (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t",
                         tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_acc    = 0;
        m_hold   = 0;
        m_hist.delete();
        m_locked = 0;
        m_inc    = 0;
        m_dec    = 0;
    endtask

    task automatic model_lock_update();
        int n;
        int alt;
        int run;
        n   = m_hist.size();
        alt = 0;
        for (int i = n - 1; i >= 1; i--) begin
            if (m_hist[i] != m_hist[i-1]) alt++;
            else break;
        end
        run = 1;
        for (int i = n - 1; i >= 1; i--) begin
            if (m_hist[i] == m_hist[i-1]) run++;
            else break;
        end
        if (alt >= LF) m_locked = 1;
        else if (m_locked && run >= UR) m_locked = 0;
    endtask

    task automatic model_step(input bit en, input bit e, input bit l);
        m_inc = 0;
        m_dec = 0;
        if (!en) begin
            model_reset();
        end else if (!m_active) begin
            m_active = 1;
        end else if (m_hold > 0) begin
            m_hold--;
        end else begin
            m_acc += (l && !e) ? 1 : ((e && !l) ? -1 : 0);
            if (m_acc == TH || m_acc == -TH) begin
                m_inc = (m_acc > 0);
                m_dec = (m_acc < 0);
                m_hist.push_back(m_acc > 0 ? 1 : -1);
                m_acc  = 0;
                m_hold = SC + 1;
                model_lock_update();
            end
        end
    endtask

    task automatic tick(input bit en, input bit e, input bit l);
        enable = en;
        early  = e;
        late   = l;
        @(posedge clock);
        model_step(en, e, l);
        #1;
        chk("inc", inc, m_inc);
        chk("dec", dec, m_dec);
        chk("locked", locked, m_locked);
        chk("busy", busy, m_hold > 0);
    endtask

    // vote in one direction until the model issues a step, then wait out settle
    task automatic step_dir(input bit up);
        int k;
        k = 0;
        while (!(m_inc || m_dec) && k < 40) begin
            tick(1, !up, up);
            k++;
        end
        chk("step_seen", m_inc || m_dec, 1);
        k = 0;
        while (m_hold > 0 && k < 20) begin
            tick(1, 0, 0);
            k++;
        end
        chk("settle_done", m_hold, 0);
    endtask

    initial begin
        int cyc;
        int first;
        int second;
        int pulses;
        int mode;
        reset  = 1'b1;
        enable = 1'b0;
        early  = 1'b0;
        late   = 1'b0;
        model_reset();
        #12;
        chk("rst_inc", inc, 0);
        chk("rst_dec", dec, 0);
        chk("rst_locked", locked, 0);
        chk("rst_busy", busy, 0);
        @(negedge clock);
        reset = 1'b0;

        // steady late: first pulse 9 ticks after enable, then every 13
        first  = 0;
        second = 0;
        for (int i = 1; i <= 40; i++) begin
            tick(1, 0, 1);
            if (inc === 1'b1 && first == 0) first = i;
            else if (inc === 1'b1 && second == 0) second = i;
        end
        chk("first_inc", first, 9);
        chk("period", second - first, 13);

        // alternating votes: never reach threshold
        tick(0, 0, 0);
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1, i[0], !i[0]);
            if (inc || dec || busy) pulses++;
        end
        chk("alt_quiet", pulses, 0);

        // lock by alternation, unlock by a run
        tick(0, 0, 0);
        step_dir(1);
        step_dir(0);
        step_dir(1);
        step_dir(0);
        chk("pre_lock", locked, 0);
        step_dir(1);
        chk("lock5", locked, 1);
        step_dir(1);
        chk("still_lock", locked, 1);
        step_dir(1);
        chk("unlock", locked, 0);

        // votes during settle are ignored; both-high holds acc
        tick(0, 0, 0);
        step_dir(1);
        tick(0, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 8; i++) tick(1, 0, 1);
        for (int i = 0; i < SC + 1; i++) tick(1, 0, 1);
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, 0);
            if (inc || dec) pulses++;
        end
        chk("settle_ignored", pulses, 0);
        tick(1, 1, 1);
        for (int i = 0; i < 7; i++) tick(1, 0, 1);
        chk("both_high_no_step", inc, 0);
        tick(1, 0, 1);
        chk("both_high_step", inc, 1);

        // enable drops on the threshold cycle
        tick(0, 0, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 7; i++) tick(1, 0, 1);
        tick(0, 0, 1);
        chk("drop_no_inc", inc, 0);
        chk("drop_idle", busy, 0);
        tick(1, 0, 0);
        for (int i = 0; i < 7; i++) tick(1, 0, 1);
        chk("reen_wait", inc, 0);
        tick(1, 0, 1);
        chk("reen_inc", inc, 1);

        // randomized traffic
        mode = 0;
        for (int i = 0; i < 600; i++) begin
            if (i % 30 == 0) mode = int'($urandom_range(0, 2));
            if (mode == 0)
                tick(($urandom % 40) != 0, ($urandom % 4) == 0,
                     ($urandom % 4) != 0);
            else if (mode == 1)
                tick(($urandom % 40) != 0, ($urandom % 4) != 0,
                     ($urandom % 4) == 0);
            else
                tick(($urandom % 40) != 0, $urandom % 2, $urandom % 2);
        end

        // asynchronous reset while inc is high
        tick(0, 0, 0);
        cyc = 0;
        while (!m_inc && cyc < 40) begin
            tick(1, 0, 1);
            cyc++;
        end
        chk("pre_rst_inc", inc, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_inc", inc, 0);
        chk("arst_dec", dec, 0);
        chk("arst_locked", locked, 0);
        chk("arst_busy", busy, 0);
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            tick(1, 0, 1);
            if (inc === 1'b1 && first == 0) first = i;
        end
        chk("post_rst_first", first, 9);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
